// File: rtl/vm_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_disp_pkg
// Description : Shared types for the vend dispense controller. Contains the
//               product codes, the dispense FSM state enum, the queued vend
//               request record and small helper functions.
// Revision    : 1.0  initial release
// ============================================================================
package vm_disp_pkg;

    localparam logic [2:0] PROD_NONE       = 3'd0;
    localparam logic [2:0] PROD_COFFEE     = 3'd1;
    localparam logic [2:0] PROD_SNACKS     = 3'd2;
    localparam logic [2:0] PROD_WATER      = 3'd3;
    localparam logic [2:0] PROD_COOLDRINKS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOTOR     = 3'd1,
        ST_WAIT_DROP = 3'd2,
        ST_EJECT_HI  = 3'd3,
        ST_EJECT_LO  = 3'd4,
        ST_DONE      = 3'd5
    } disp_state_t;

    typedef struct packed {
        logic [2:0] prod;
        logic [1:0] change;
    } vend_entry_t;

    // Codes 1..4 are real products; 0 means "no vend" and 5..7 are unused.
    function automatic logic is_valid_prod(input logic [2:0] p);
        return (p != PROD_NONE) && (p <= PROD_COOLDRINKS);
    endfunction

    // Slot motor drive: bit k-1 for product k, never more than one bit.
    function automatic logic [3:0] prod_onehot(input logic [2:0] p);
        logic [3:0] oh;
        oh = 4'b0000;
        case (p)
            PROD_COFFEE:     oh = 4'b0001;
            PROD_SNACKS:     oh = 4'b0010;
            PROD_WATER:      oh = 4'b0100;
            PROD_COOLDRINKS: oh = 4'b1000;
            default:         oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vm_disp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vm_disp_fifo
// Description : Synchronous vend-request FIFO, DEPTH entries (power of 2).
//               A push while full is accepted only when a pop happens on the
//               same edge; otherwise it is ignored (caller flags overflow).
// Ports       : clk, reset (async active-low), push/push_data, pop,
//               head (current oldest entry), full, empty
// Revision    : 1.0  initial release
// ============================================================================
module vm_disp_fifo
    import vm_disp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  vend_entry_t push_data,
    input  logic        pop,
    output vend_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    vend_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/vm_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vm_dispense_ctrl
// Description : Dispense stage behind the vending FSM. Queues one-cycle vend
//               pulses, runs the slot motor, waits for drop confirmation,
//               ejects change coins and reports faults. Never back-pressures.
// Ports       : clk, reset (async active-low)
//               vend_prod[2:0], vend_change[1:0]  vend request pulse
//               drop_sensor, clear_flags           sensor / flag clear
//               motor_en[3:0], coin_eject          actuator drives (registered)
//               busy, vend_done, fault, overflow   status
//               stats_sel[1:0], stats_cnt          only with VM_DISP_STATS_EN
// Options     : VM_DISP_STATS_EN - per-product saturating vend counters
// Revision    : 1.0  initial release
// ============================================================================
module vm_dispense_ctrl
    import vm_disp_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int MOTOR_CYCLES   = 8,
    parameter int SENSOR_TIMEOUT = 64,
    parameter int EJECT_ON       = 2,
    parameter int EJECT_OFF      = 2
`ifdef VM_DISP_STATS_EN
    ,
    parameter int STAT_W         = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        vend_prod,
    input  logic [1:0]        vend_change,
    input  logic              drop_sensor,
    input  logic              clear_flags,
    output logic [3:0]        motor_en,
    output logic              coin_eject,
    output logic              busy,
    output logic              vend_done,
    output logic              fault,
    output logic              overflow
`ifdef VM_DISP_STATS_EN
    ,
    input  logic [1:0]        stats_sel,
    output logic [STAT_W-1:0] stats_cnt
`endif
);

    localparam int MAX_PHASE = max2(max2(MOTOR_CYCLES, SENSOR_TIMEOUT), max2(EJECT_ON, EJECT_OFF));
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);

    localparam logic [CNT_W-1:0] MOTOR_LAST   = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(SENSOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] EJ_ON_LAST   = CNT_W'(EJECT_ON - 1);
    localparam logic [CNT_W-1:0] EJ_OFF_LAST  = CNT_W'(EJECT_OFF - 1);

    disp_state_t      state;
    disp_state_t      state_nxt;
    disp_state_t      eject_entry;
    logic [CNT_W-1:0] phase_cnt;
    logic [2:0]       work_prod;
    logic [1:0]       coins_left;
    logic             drop_latch;
    logic             fault_set;
    logic             coin_dec;
    logic             vend_ok;

    vend_entry_t      req;
    vend_entry_t      head;
    logic             push_req;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_set;

    assign req      = {vend_prod, vend_change};
    assign push_req = is_valid_prod(vend_prod);
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign ovf_set  = push_req && fifo_full && !pop;
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    assign vend_ok  = (state == ST_DONE) && drop_latch;

    vm_disp_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt   = state;
        fault_set   = 1'b0;
        coin_dec    = 1'b0;
        // A zero-change vend skips the ejector entirely.
        eject_entry = (coins_left == 2'd0) ? ST_DONE : ST_EJECT_HI;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_MOTOR;
            end
            ST_MOTOR: begin
                // Sensor in the final motor cycle counts as seen.
                if (phase_cnt == MOTOR_LAST)
                    state_nxt = (drop_latch || drop_sensor) ? eject_entry : ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (drop_sensor) begin
                    state_nxt = eject_entry;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    // Timed out: still refund the change.
                    fault_set = 1'b1;
                    state_nxt = eject_entry;
                end
            end
            ST_EJECT_HI: begin
                if (phase_cnt == EJ_ON_LAST) state_nxt = ST_EJECT_LO;
            end
            ST_EJECT_LO: begin
                if (phase_cnt == EJ_OFF_LAST) begin
                    coin_dec  = 1'b1;
                    state_nxt = (coins_left == 2'd1) ? ST_DONE : ST_EJECT_HI;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            work_prod  <= PROD_NONE;
            coins_left <= 2'd0;
            drop_latch <= 1'b0;
            motor_en   <= 4'b0000;
            coin_eject <= 1'b0;
            vend_done  <= 1'b0;
            fault      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Each phase counts from zero; idle holds the counter cleared.
            if ((state_nxt != state) || (state == ST_IDLE))
                phase_cnt <= '0;
            else
                phase_cnt <= phase_cnt + 1'b1;

            if (pop) begin
                work_prod  <= head.prod;
                coins_left <= head.change;
                drop_latch <= 1'b0;
            end else begin
                if (coin_dec) coins_left <= coins_left - 2'd1;
                if (((state == ST_MOTOR) || (state == ST_WAIT_DROP)) && drop_sensor)
                    drop_latch <= 1'b1;
            end

            // Actuator outputs are a registered image of the current state.
            motor_en   <= (state == ST_MOTOR) ? prod_onehot(work_prod) : 4'b0000;
            coin_eject <= (state == ST_EJECT_HI);
            vend_done  <= vend_ok;

            // Set beats a simultaneous clear.
            if (fault_set)        fault <= 1'b1;
            else if (clear_flags) fault <= 1'b0;
            if (ovf_set)          overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
        end
    end

`ifdef VM_DISP_STATS_EN
    logic [STAT_W-1:0] stat_cnt [4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) stat_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (vend_ok && (work_prod == 3'(k + 1)) && (stat_cnt[k] != '1))
                    stat_cnt[k] <= stat_cnt[k] + 1'b1;
            end
        end
    end

    assign stats_cnt = stat_cnt[stats_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_vm_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vm_dispense_ctrl
// Description : Self-checking bench for vm_dispense_ctrl. Directed vector
//               table, multi-cycle scenario sequences and a random phase,
//               all compared against a job-timeline reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vm_dispense_ctrl;

    localparam int DEPTH = 4;
    localparam int M     = 8;
    localparam int T     = 64;
    localparam int ON    = 2;
    localparam int OFF   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] vend_prod;
    logic [1:0] vend_change;
    logic       drop_sensor;
    logic       clear_flags;
    logic [3:0] motor_en;
    logic       coin_eject;
    logic       busy;
    logic       vend_done;
    logic       fault;
    logic       overflow;
`ifdef VM_DISP_STATS_EN
    logic [1:0]  stats_sel;
    logic [15:0] stats_cnt;
`endif

    always #5 clk = ~clk;

    vm_dispense_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .MOTOR_CYCLES   (M),
        .SENSOR_TIMEOUT (T),
        .EJECT_ON       (ON),
        .EJECT_OFF      (OFF)
`ifdef VM_DISP_STATS_EN
        ,
        .STAT_W         (16)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vend_prod   (vend_prod),
        .vend_change (vend_change),
        .drop_sensor (drop_sensor),
        .clear_flags (clear_flags),
        .motor_en    (motor_en),
        .coin_eject  (coin_eject),
        .busy        (busy),
        .vend_done   (vend_done),
        .fault       (fault),
        .overflow    (overflow)
`ifdef VM_DISP_STATS_EN
        ,
        .stats_sel   (stats_sel),
        .stats_cnt   (stats_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (job timeline) ----------------
    typedef struct {
        int prod;
        int change;
    } job_t;

    job_t       q[$];
    job_t       job;
    bit         active;
    int         c;          // cycles elapsed since the job was taken
    bit         confirmed;
    int         sense_end;  // first cycle after sensing finished, -1 unknown
    bit         m_fault;
    bit         m_ovf;
    int         m_stats[4];
    logic [3:0] e_motor;
    bit         e_coin;
    bit         e_done;
    bit         e_busy;

    // scenario observation
    int         n_rise;
    int         n_hi;
    int         n_done;
    int         motor_log[$];
    logic       prev_coin;
    logic [3:0] prev_motor;
    int         exp_order[5] = '{1, 2, 3, 4, 3};

    typedef struct {
        logic [2:0] vp;
        logic [1:0] vc;
        logic       ds;
        logic       cf;
        logic [3:0] motor;
        logic       coin;
        logic       bsy;
        logic       done;
    } vec_t;
    vec_t tbl[$];

    task automatic model_reset();
        q.delete();
        active    = 1'b0;
        c         = 0;
        confirmed = 1'b0;
        sense_end = -1;
        m_fault   = 1'b0;
        m_ovf     = 1'b0;
        for (int k = 0; k < 4; k++) m_stats[k] = 0;
        e_motor   = 4'b0000;
        e_coin    = 1'b0;
        e_done    = 1'b0;
        e_busy    = 1'b0;
        prev_coin  = 1'b0;
        prev_motor = 4'b0000;
    endtask

    task automatic model_edge(input int vp, input int vc, input bit ds, input bit cf);
        bit   f_set;
        bit   o_set;
        job_t nj;
        e_motor = 4'b0000;
        e_coin  = 1'b0;
        e_done  = 1'b0;
        f_set   = 1'b0;
        o_set   = 1'b0;
        if (active) begin
            if (c < M) begin
                e_motor = 4'(1 << (job.prod - 1));
                if (ds) confirmed = 1'b1;
                if (c == M - 1 && confirmed) sense_end = M;
            end else if (sense_end < 0) begin
                if (ds) begin
                    confirmed = 1'b1;
                    sense_end = c + 1;
                end else if (c == M + T - 1) begin
                    f_set     = 1'b1;
                    sense_end = c + 1;
                end
            end else if (c < sense_end + job.change * (ON + OFF)) begin
                e_coin = ((c - sense_end) % (ON + OFF)) < ON;
            end else begin
                e_done = confirmed;
                active = 1'b0;
                if (confirmed && m_stats[job.prod - 1] < 65535)
                    m_stats[job.prod - 1]++;
            end
            c++;
        end else if (q.size() > 0) begin
            job       = q.pop_front();
            active    = 1'b1;
            c         = 0;
            confirmed = 1'b0;
            sense_end = -1;
        end
        if (vp >= 1 && vp <= 4) begin
            if (q.size() < DEPTH) begin
                nj.prod   = vp;
                nj.change = vc;
                q.push_back(nj);
            end else begin
                o_set = 1'b1;
            end
        end
        if (f_set)   m_fault = 1'b1;
        else if (cf) m_fault = 1'b0;
        if (o_set)   m_ovf = 1'b1;
        else if (cf) m_ovf = 1'b0;
        e_busy = active || (q.size() > 0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, motor_en, coin_eject, busy, vend_done, fault, overflow};
    endfunction

    task automatic step(input logic [2:0] vp, input logic [1:0] vc, input logic ds, input logic cf);
        vend_prod   = vp;
        vend_change = vc;
        drop_sensor = ds;
        clear_flags = cf;
        @(posedge clk);
        model_edge(int'(vp), int'(vc), ds, cf);
        #1;
        chk("outputs{motor,coin,busy,done,fault,ovf}", outs(),
            {23'd0, e_motor, e_coin, e_busy, e_done, m_fault, m_ovf});
        if (coin_eject && !prev_coin) n_rise++;
        if (coin_eject) n_hi++;
        if (vend_done) n_done++;
        if (motor_en != 4'b0000 && prev_motor == 4'b0000) begin
            for (int k = 0; k < 4; k++)
                if (motor_en[k]) motor_log.push_back(k + 1);
        end
        prev_coin  = coin_eject;
        prev_motor = motor_en;
    endtask

    task automatic add_vec(input logic [2:0] vp, input logic [1:0] vc, input logic ds,
                           input logic [3:0] mo, input logic co, input logic bs, input logic dn);
        vec_t v;
        v.vp = vp; v.vc = vc; v.ds = ds; v.cf = 1'b0;
        v.motor = mo; v.coin = co; v.bsy = bs; v.done = dn;
        tbl.push_back(v);
    endtask

    task automatic clear_obs();
        n_rise = 0;
        n_hi   = 0;
        n_done = 0;
        motor_log.delete();
    endtask

`ifdef VM_DISP_STATS_EN
    task automatic chk_stats();
        for (int k = 0; k < 4; k++) begin
            stats_sel = 2'(k);
            #1;
            chk("stats_cnt", 32'(stats_cnt), 32'(m_stats[k]));
        end
    endtask
`endif

    initial begin
        logic [2:0] rvp;
        logic [1:0] rvc;
        logic       rds;
        logic       rcf;
        bit         found;
        int         rate;

        reset       = 1'b0;
        vend_prod   = 3'd0;
        vend_change = 2'd0;
        drop_sensor = 1'b0;
        clear_flags = 1'b0;
`ifdef VM_DISP_STATS_EN
        stats_sel   = 2'd0;
`endif
        model_reset();
        clear_obs();

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_state", outs(), 32'd0);
        reset = 1'b1;

        // Directed table: ignored codes, then a single coffee vend, change 0,
        // sensor during motor run.
        add_vec(3'd5, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        add_vec(3'd0, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        add_vec(3'd7, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        add_vec(3'd1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);  // push at t
        add_vec(3'd0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);  // pop at t+1
        add_vec(3'd0, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);  // motor from t+2
        add_vec(3'd0, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);  // sensor
        for (int k = 0; k < 6; k++)
            add_vec(3'd0, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
        add_vec(3'd0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);  // vend_done
        add_vec(3'd0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vp, tbl[i].vc, tbl[i].ds, tbl[i].cf);
            chk("table_vec", outs(),
                {23'd0, tbl[i].motor, tbl[i].coin, tbl[i].bsy, tbl[i].done, 2'b00});
        end

        // Water, 2 coins, sensor only after the motor stopped.
        clear_obs();
        step(3'd3, 2'd2, 1'b0, 1'b0);
        for (int i = 1; i < 30; i++) step(3'd0, 2'd0, (i == 11), 1'b0);
        chk("s2_coin_pulses", 32'(n_rise), 32'd2);
        chk("s2_coin_high_cycles", 32'(n_hi), 32'd4);
        chk("s2_vend_done", 32'(n_done), 32'd1);

        // Snacks, 1 coin, sensor never fires: timeout fault, refund, no done.
        clear_obs();
        step(3'd2, 2'd1, 1'b0, 1'b0);
        for (int i = 1; i < 85; i++) step(3'd0, 2'd0, 1'b0, 1'b0);
        chk("s3_coin_pulses", 32'(n_rise), 32'd1);
        chk("s3_vend_done", 32'(n_done), 32'd0);
        chk("s3_fault_set", 32'(fault), 32'd1);
        step(3'd0, 2'd0, 1'b0, 1'b1);
        chk("s3_fault_cleared", 32'(fault), 32'd0);

        // Six requests two cycles apart: FIFO fills, sixth is dropped.
        clear_obs();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0)
                step(3'(exp_order[i / 2 > 4 ? 1 : i / 2] + ((i / 2 == 5) ? 0 : 0)),
                     2'((i / 2 == 1) ? 1 : (i / 2 == 3) ? 2 : (i / 2 == 4) ? 1 : 0), 1'b1, 1'b0);
            else
                step(3'd0, 2'd0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 110; i++) step(3'd0, 2'd0, 1'b1, 1'b0);
        chk("s4_overflow", 32'(overflow), 32'd1);
        chk("s4_vend_done", 32'(n_done), 32'd5);
        chk("s4_order_len", 32'(motor_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < motor_log.size(); k++)
            chk("s4_order", 32'(motor_log[k]), 32'(exp_order[k]));

        // Reset asserted mid-EJECT_HI with another request queued.
        step(3'd3, 2'd1, 1'b1, 1'b0);
        step(3'd4, 2'd0, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(3'd0, 2'd0, 1'b1, 1'b0);
            if (coin_eject) found = 1'b1;
        end
        chk("eject_reached", 32'(found), 32'd1);
        vend_prod   = 3'd0;
        drop_sensor = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("reset_async", outs(), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold", outs(), 32'd0);
        model_reset();
        #2 reset = 1'b1;

`ifdef VM_DISP_STATS_EN
        for (int v = 0; v < 3; v++) begin
            step(3'd1, 2'd0, 1'b1, 1'b0);
            for (int i = 0; i < 14; i++) step(3'd0, 2'd0, 1'b1, 1'b0);
        end
        stats_sel = 2'd0;
        #1;
        chk("stats_coffee", 32'(stats_cnt), 32'd3);
        chk_stats();
`endif

        // Random phase with bursts to provoke overflow.
        for (int i = 0; i < 3000; i++) begin
            rate = ((i % 1000) < 150) ? 2 : 9;
            rvp  = ($urandom_range(0, rate) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            rvc  = 2'($urandom_range(0, 3));
            rds  = ($urandom_range(0, 19) == 0);
            rcf  = ($urandom_range(0, 49) == 0);
            step(rvp, rvc, rds, rcf);
`ifdef VM_DISP_STATS_EN
            if (i % 500 == 499) chk_stats();
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
